// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// div_pkg : shared types and constants for the div_unit integer divider
// Revision: 1.0
// ============================================================================
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_NORM = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

  // Same bit ordering as the ALU flag nibble
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// div_step : one combinational restoring-division iteration
// Revision: 1.0
// ============================================================================
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  // The shifted remainder is always below 2*divisor, so the MSB of the
  // WIDTH+1-bit difference is exactly the sign of the trial subtraction.
  assign w_shift = {rem_i, bit_i};
  assign w_diff  = w_shift - {1'b0, dvs_i};
  assign qbit_o  = ~w_diff[WIDTH];
  assign rem_o   = qbit_o ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// div_unit : multi-cycle radix-2 restoring UDIV/SDIV with start/busy/done
// Revision: 1.0
// ============================================================================
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic [3:0]       DivFlags
);

  localparam int               CW        = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]    C_LAST    = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] C_INT_MIN = WIDTH'(INT_MIN >> (32 - WIDTH));

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, dvd_q, dvs_q;
  logic             qsign_q, rsign_q;
  logic [WIDTH-1:0] quo_out_q, rem_out_q;
  logic [3:0]       flags_q;

  logic             w_accept, w_div0, w_ovf;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [WIDTH-1:0] w_rem_nxt;
  logic             w_qbit;
  logic             w_load, w_c, w_v;
  logic [WIDTH-1:0] w_quo_ld, w_rem_ld;
  logic [3:0]       w_flags;

  assign w_accept = Start & ((state_q == S_IDLE) | (state_q == S_DONE));
  assign w_div0   = (B == '0);
  assign w_ovf    = Signed & (A == C_INT_MIN) & (B == '1);
  assign w_a_mag  = (Signed & A[WIDTH-1]) ? -A : A;
  assign w_b_mag  = (Signed & B[WIDTH-1]) ? -B : B;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .bit_i  (dvd_q[WIDTH-1]),
    .dvs_i  (dvs_q),
    .rem_o  (w_rem_nxt),
    .qbit_o (w_qbit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) state_d = (w_div0 | w_ovf) ? S_DONE : S_RUN;
        else       state_d = S_IDLE;
      end
      S_RUN:   if (cnt_q == C_LAST) state_d = S_NORM;
      S_NORM:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    Busy = (state_q == S_RUN) | (state_q == S_NORM);
    Done = (state_q == S_DONE);
  end

  // The dividend register doubles as the quotient: bits shift in at the LSB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
    end else if (w_accept & ~w_div0 & ~w_ovf) begin
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= w_a_mag;
      dvs_q   <= w_b_mag;
      qsign_q <= Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
      rsign_q <= Signed & A[WIDTH-1];
    end else if (state_q == S_RUN) begin
      cnt_q   <= cnt_q + CW'(1);
      rem_q   <= w_rem_nxt;
      dvd_q   <= {dvd_q[WIDTH-2:0], w_qbit};
    end
  end

  always_comb begin
    w_load   = 1'b0;
    w_quo_ld = qsign_q ? -dvd_q : dvd_q;
    w_rem_ld = rsign_q ? -rem_q : rem_q;
    w_c      = 1'b0;
    w_v      = 1'b0;
    if (state_q == S_NORM) begin
      w_load = 1'b1;
    end else if (w_accept & w_div0) begin
      w_load   = 1'b1;
      w_quo_ld = '0;
      w_rem_ld = A;
      w_c      = 1'b1;
    end else if (w_accept & w_ovf) begin
      w_load   = 1'b1;
      w_quo_ld = C_INT_MIN;
      w_rem_ld = '0;
      w_v      = 1'b1;
    end
    w_flags         = 4'b0000;
    w_flags[FLAG_N] = w_quo_ld[WIDTH-1];
    w_flags[FLAG_Z] = (w_quo_ld == '0);
    w_flags[FLAG_C] = w_c;
    w_flags[FLAG_V] = w_v;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quo_out_q <= '0;
      rem_out_q <= '0;
      flags_q   <= 4'b0000;
    end else if (w_load) begin
      quo_out_q <= w_quo_ld;
      rem_out_q <= w_rem_ld;
      flags_q   <= w_flags;
    end
  end

  assign Quotient  = quo_out_q;
  assign Remainder = rem_out_q;
  assign DivFlags  = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// tb_div_unit : table-driven, scoreboarded bench for div_unit
// Revision: 1.0
// ============================================================================
module tb_div_unit;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic [3:0]  f;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic        Signed = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        Busy, Done;
  logic [31:0] Quotient, Remainder;
  logic [3:0]  DivFlags;

  int   n_checks = 0;
  int   n_err = 0;
  exp_t sb[$];

  div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .Start     (Start),
    .Signed    (Signed),
    .A         (A),
    .B         (B),
    .Busy      (Busy),
    .Done      (Done),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .DivFlags  (DivFlags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    if (b == 32'd0) begin
      e.q = '0; e.r = a; e.f = 4'b0110;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000; e.r = '0; e.f = 4'b1001;
    end else begin
      if (s) begin
        e.q = $signed(a) / $signed(b);
        e.r = $signed(a) % $signed(b);
      end else begin
        e.q = a / b;
        e.r = a % b;
      end
      e.f = {e.q[31], (e.q == 32'd0), 2'b00};
    end
    return e;
  endfunction

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic s,
                              input logic [31:0] q, input logic [31:0] r, input logic [3:0] f);
    vec_t v;
    v.a = a; v.b = b; v.s = s;
    v.e.q = q; v.e.r = r; v.e.f = f;
    return v;
  endfunction

  // Scoreboard: pop one expectation per Done pulse
  always @(negedge clk) begin
    if (!reset && Done) begin
      chk("busy_with_done", {31'd0, Busy}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", Quotient, e.q);
        chk("remainder", Remainder, e.r);
        chk("flags", {28'd0, DivFlags}, {28'd0, e.f});
      end
    end
  end

  task automatic wait_done(input int exp_lat, input int exp_busy, input string tag);
    int lat = 0;
    int nb = 0;
    while (!Done && lat < 200) begin
      if (Busy) nb++;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_busy_cycles"}, nb, exp_busy);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input exp_t e, input string tag);
    int lat;
    @(negedge clk);
    A = a; B = b; Signed = s; Start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    Start = 1'b0;
    lat = (e.f[1] | e.f[0]) ? 0 : 33;
    wait_done(lat, lat, tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl[12];
    int   n_done;

    tbl[0]  = mk(32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          4'b0000);
    tbl[1]  = mk(32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  4'b1000);
    tbl[2]  = mk(32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          4'b1001);
    tbl[3]  = mk(32'd5,          32'd0,          1'b0, 32'd0,          32'd5,          4'b0110);
    tbl[4]  = mk(32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          4'b1000);
    tbl[5]  = mk(32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 32'd3,          32'hFFFF_FFFF,  4'b0000);
    tbl[6]  = mk(32'd3,          32'd5,          1'b0, 32'd0,          32'd3,          4'b0100);
    tbl[7]  = mk(32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'd1,          32'd0,          4'b0000);
    tbl[8]  = mk(32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  4'b0100);
    tbl[9]  = mk(32'h8000_0000,  32'd1,          1'b1, 32'h8000_0000,  32'd0,          4'b1000);
    tbl[10] = mk(32'hFFFF_FFFB,  32'd0,          1'b1, 32'd0,          32'hFFFF_FFFB,  4'b0110);
    tbl[11] = mk(32'hDEAD_BEEF,  32'd16,         1'b0, 32'h0DEA_DBEE,  32'd15,         4'b0000);

    // Reset state
    @(negedge clk);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_quotient", Quotient, 32'd0);
    chk("rst_remainder", Remainder, 32'd0);
    chk("rst_flags", {28'd0, DivFlags}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].e, $sformatf("vec%0d", i));

    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra, rb;
      logic        rs;
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      rs = 1'($urandom_range(0, 1));
      run_op(ra, rb, rs, model(ra, rb, rs), $sformatf("rnd%0d", i));
    end

    // Start re-pulsed mid-RUN must be ignored
    @(negedge clk);
    A = 32'hFFFF_FFFF; B = 32'd1; Signed = 1'b0; Start = 1'b1;
    sb.push_back(model(32'hFFFF_FFFF, 32'd1, 1'b0));
    @(negedge clk);
    Start = 1'b0;
    repeat (5) @(negedge clk);
    A = 32'd3; B = 32'd3; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    wait_done(27, 27, "repulse");

    // Start held in DONE: next operation with no idle cycle
    A = 32'd9; B = 32'd3; Signed = 1'b0; Start = 1'b1;
    sb.push_back(model(32'd9, 32'd3, 1'b0));
    @(negedge clk);
    Start = 1'b0;
    wait_done(33, 33, "b2b");

    // Asynchronous reset ten cycles into RUN
    @(negedge clk);
    A = 32'd1000; B = 32'd3; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", {31'd0, Busy}, 32'd0);
    chk("arst_done", {31'd0, Done}, 32'd0);
    chk("arst_quotient", Quotient, 32'd0);
    chk("arst_remainder", Remainder, 32'd0);
    chk("arst_flags", {28'd0, DivFlags}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (Done) n_done++;
    end
    chk("arst_no_done", n_done, 0);

    run_op(32'd10, 32'd3, 1'b0, model(32'd10, 32'd3, 1'b0), "post_reset");

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
